div_ratio_ctrl: RTL

DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

---
 rtl/div_ratio_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/div_ratio_ctrl.sv
// div_ratio_ctrl: glitch-free ratio changer for a free-running clock divider.
// A shadow counter tracks the divider phase. A new ratio is applied only on
// the divider's falling edge (shadow == div_ratio-1). At that point the divider
// is held in reset for HOLD_CYC cycles and then released with the new ratio.
// Optional feature macro: DIV_RATIO_CLAMP_EN. When it is defined, ratios below 2
// are clamped to 2. When it is undefined, ratios below 2 are rejected with err.
module div_ratio_ctrl #(
    parameter logic [31:0] RESET_RATIO = 32'd10,
    parameter int          HOLD_CYC    = 2
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_ratio,
    output logic        req_ready,
    output logic [31:0] div_ratio,
    output logic        div_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_WAIT_EDGE = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RELEASE   = 3'd4
    } state_t;

    // Last value of the hold/init cycle counter before moving on
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

    // Ratio actually applied for a request (clamped when the feature is on)
    function automatic logic [31:0] eff_ratio(input logic [31:0] r);
`ifdef DIV_RATIO_CLAMP_EN
        eff_ratio = (r < 32'd2) ? 32'd2 : r;
`else
        eff_ratio = r;
`endif
    endfunction

    // Whether a requested ratio can be processed at all
    function automatic logic ratio_ok(input logic [31:0] r);
`ifdef DIV_RATIO_CLAMP_EN
        ratio_ok = (r == r);
`else
        ratio_ok = (r >= 32'd2);
`endif
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] div_ratio_q, div_ratio_d;
    logic        div_rst_n_q, div_rst_n_d;
    logic [31:0] shadow_q, shadow_d;
    logic        req_ready_q, req_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] ratio_m1_s;
    logic [31:0] req_eff_s;
    logic        req_fire_s;

    assign ratio_m1_s = div_ratio_q - 32'd1;
    assign req_eff_s  = eff_ratio(req_ratio);
    assign req_fire_s = req_valid & req_ready_q;

    // Next-state, datapath and registered-output logic of the change sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        div_ratio_d = div_ratio_q;
        div_rst_n_d = div_rst_n_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_INIT: begin
                div_rst_n_d = 1'b0;
                if (cnt_q == HOLD_LAST) begin
                    state_d     = ST_IDLE;
                    cnt_d       = 4'd0;
                    div_rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_IDLE: begin
                if (req_fire_s) begin
                    if (!ratio_ok(req_ratio)) begin
                        err_d = 1'b1;
                    end else if (req_eff_s == div_ratio_q) begin
                        done_d = 1'b1;
                    end else begin
                        pend_d  = req_eff_s;
                        state_d = ST_WAIT_EDGE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_EDGE: begin
                // Divider falling edge: safe point to reset it and swap ratio
                if (shadow_q == ratio_m1_s) begin
                    state_d     = ST_HOLD;
                    cnt_d       = 4'd0;
                    div_rst_n_d = 1'b0;
                    div_ratio_d = pend_q;
                end else begin
                    state_d = ST_WAIT_EDGE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d     = ST_RELEASE;
                    cnt_d       = 4'd0;
                    div_rst_n_d = 1'b1;
                    done_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_INIT;
                cnt_d       = 4'd0;
                div_rst_n_d = 1'b0;
            end
        endcase

        if (!div_rst_n_q) begin
            shadow_d = 32'd0;
        end else if (shadow_q == ratio_m1_s) begin
            shadow_d = 32'd0;
        end else begin
            shadow_d = shadow_q + 32'd1;
        end

        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, counters and output registers; reset abandons any change
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= 4'd0;
            pend_q      <= RESET_RATIO;
            div_ratio_q <= RESET_RATIO;
            div_rst_n_q <= 1'b0;
            shadow_q    <= 32'd0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            div_ratio_q <= div_ratio_d;
            div_rst_n_q <= div_rst_n_d;
            shadow_q    <= shadow_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign div_ratio = div_ratio_q;
    assign div_rst_n = div_rst_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
